ram_arbiter32: RTL and testbench

- Shares the single-port 32x8 synchronous RAM (ram32_8) between two requesters: port 0, the binary-search datapath (read-only in practice), and port 1, a host/loader that writes and reads the sorted array.
- Round-robin arbitration, one RAM transaction per cycle.
- Optional bounded lock lets the granted requester keep the RAM for back-to-back accesses.
- Sits between the controller/datapath pair and ram32_8 in the DE1_SoC top level.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 29 ++
 rtl/ram_arbiter32.sv | 160 ++++++++++++++++
 tb/tb_ram_arbiter32.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and defaults for the ram32_8 arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (32 x 8).
//   port_id_t               : requester identity; NONE marks "no port"
//                             for last grant, lock owner and read owner.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    P0   = 2'd0,
    P1   = 2'd1,
    NONE = 2'd2
  } port_id_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
//   Pure combinational two-way round-robin selector.
//   Ports:
//     req0, req1 : in  request per port
//     last_gnt   : in  port granted most recently
//     pick       : out selected port, NONE when nobody requests
//   On a tie the port opposite last_gnt wins, so last_gnt = NONE or P1
//   favours port 0.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last_gnt,
  output port_id_t pick
);

  always_comb begin
    pick = NONE;
    if (req0 && req1) begin
      pick = (last_gnt == P0) ? P1 : P0;
    end else if (req0) begin
      pick = P0;
    end else if (req1) begin
      pick = P1;
    end
  end

endmodule

// File: rtl/ram_arbiter32.sv
// ram_arbiter32
//   Shares the single-port ram32_8 between the binary-search datapath
//   (port 0) and the host/loader (port 1). One RAM transaction per cycle,
//   round-robin fairness, optional bounded lock for back-to-back access.
//
//   Handshake (both ports): req_k is "valid", gnt_k is "ready". A
//   transaction transfers in the cycle where req_k && gnt_k. gnt is
//   combinational, so an ungranted requester keeps req/we/addr/wdata/lock
//   stable and simply waits. Reads return exactly one cycle after the
//   transfer as rvalid_k/rdata_k.
//
//   Ports:
//     clk, reset            : clock, asynchronous active-low reset
//     req/we/lock/addr/wdata: per-port request (k = 0, 1)
//     gnt0, gnt1            : combinational grant
//     rvalid0/1, rdata0/1   : read return, rdata is 0 when rvalid is low
//     mem_addr/wdata/wren   : to ram32_8; mem_rdata from ram32_8
//     busy                  : a port currently holds a lock
//     dbg_state             : {last_gnt, lock_owner, rd_owner, lock_cnt}
module ram_arbiter32
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [13:0]       dbg_state
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  port_id_t   last_gnt, lock_owner, rd_owner;
  logic [7:0] lock_cnt;

  port_id_t   nxt_last, nxt_owner, nxt_rd;
  logic [7:0] nxt_cnt;

  port_id_t   rr_sel, sel;
  logic       sel_we, sel_lock;

  rr_pick2 u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .pick     (rr_sel)
  );

  // A lock overrides fairness until it has been used LOCK_MAX times; once
  // exhausted, the owner keeps the RAM only if the other port is idle.
  // When the lock is exhausted and both request, last_gnt equals the owner,
  // so the round-robin pick already hands over to the other port.
  always_comb begin
    sel = rr_sel;
    if (lock_owner == P0 && req0 && (lock_cnt < LOCK_MAX_C || !req1)) begin
      sel = P0;
    end else if (lock_owner == P1 && req1 && (lock_cnt < LOCK_MAX_C || !req0)) begin
      sel = P1;
    end
    if (!reset) begin
      sel = NONE;
    end
  end

  assign gnt0 = (sel == P0);
  assign gnt1 = (sel == P1);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    sel_we    = 1'b1;
    sel_lock  = 1'b0;
    case (sel)
      P0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_wren  = we0;
        sel_we    = we0;
        sel_lock  = lock0;
      end
      P1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_wren  = we1;
        sel_we    = we1;
        sel_lock  = lock1;
      end
      default: ;
    endcase
  end

  // Next state. Any cycle without a grant, or a grant without lock,
  // releases the lock.
  always_comb begin
    nxt_last  = last_gnt;
    nxt_owner = NONE;
    nxt_cnt   = '0;
    nxt_rd    = NONE;
    if (sel != NONE) begin
      nxt_last = sel;
      if (!sel_we) begin
        nxt_rd = sel;
      end
      if (sel_lock) begin
        nxt_owner = sel;
        if (lock_owner == sel) begin
          nxt_cnt = (lock_cnt < LOCK_MAX_C) ? lock_cnt + 8'd1 : lock_cnt;
        end else begin
          nxt_cnt = 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt   <= P1;
      lock_owner <= NONE;
      lock_cnt   <= '0;
      rd_owner   <= NONE;
    end else begin
      last_gnt   <= nxt_last;
      lock_owner <= nxt_owner;
      lock_cnt   <= nxt_cnt;
      rd_owner   <= nxt_rd;
    end
  end

  // rd_owner is cleared asynchronously, so rvalid drops with reset.
  assign rvalid0   = (rd_owner == P0);
  assign rvalid1   = (rd_owner == P1);
  assign rdata0    = rvalid0 ? mem_rdata : '0;
  assign rdata1    = rvalid1 ? mem_rdata : '0;
  assign busy      = (lock_owner != NONE);
  assign dbg_state = {last_gnt, lock_owner, rd_owner, lock_cnt};

endmodule

// File: tb/tb_ram_arbiter32.sv
module tb_ram_arbiter32;
  import ram_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  always #10 clk = ~clk;

  logic       req0, req1, we0, we1, lock0, lock1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy;
  logic [7:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;
  logic [13:0] dbg_state;

  ram_arbiter32 #(.ADDR_W(5), .DATA_W(8), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Behavioural ram32_8: registered read, write on wren.
  logic [7:0] ram_mem [32];
  always @(posedge clk) begin
    if (mem_wren) ram_mem[mem_addr] <= mem_wdata;
    mem_rdata <= ram_mem[mem_addr];
  end

  // Expected memory contents, maintained from the stimulus only.
  logic [7:0] ref_mem [32];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int tb_last  = 1;
  logic [8:0] exp_q[$];   // {port, data}
  logic [8:0] e;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Each negedge: an entry at the head of the queue belongs to this cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("rvalid0", 32'(rvalid0), 32'(!e[8]));
        check_eq("rvalid1", 32'(rvalid1), 32'(e[8]));
        check_eq("rdata", 32'(e[8] ? rdata1 : rdata0), 32'(e[7:0]));
        check_eq("rdata_other", 32'(e[8] ? rdata0 : rdata1), 32'd0);
      end else begin
        check_eq("rvalid_idle", 32'({rvalid1, rvalid0}), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drv0(input logic r, input logic w, input logic [4:0] a,
                      input logic [7:0] d, input logic l);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [4:0] a,
                      input logic [7:0] d, input logic l);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
  endtask

  // One bus cycle with expected grant g (0, 1, or -1 for none).
  task automatic step(input int g);
    @(negedge clk);
    check_eq("gnt0", 32'(gnt0), 32'(g == 0));
    check_eq("gnt1", 32'(gnt1), 32'(g == 1));
    if (g == 0) begin
      check_eq("mem_addr", 32'(mem_addr), 32'(addr0));
      check_eq("mem_wren", 32'(mem_wren), 32'(we0));
      if (we0) begin
        check_eq("mem_wdata", 32'(mem_wdata), 32'(wdata0));
        ref_mem[addr0] = wdata0;
      end
    end else if (g == 1) begin
      check_eq("mem_addr", 32'(mem_addr), 32'(addr1));
      check_eq("mem_wren", 32'(mem_wren), 32'(we1));
      if (we1) begin
        check_eq("mem_wdata", 32'(mem_wdata), 32'(wdata1));
        ref_mem[addr1] = wdata1;
      end
    end else begin
      check_eq("idle_addr", 32'(mem_addr), 32'd0);
      check_eq("idle_wren", 32'(mem_wren), 32'd0);
      check_eq("idle_wdata", 32'(mem_wdata), 32'd0);
    end
    @(posedge clk);
    if (g == 0 && !we0) exp_q.push_back({1'b0, ref_mem[addr0]});
    if (g == 1 && !we1) exp_q.push_back({1'b1, ref_mem[addr1]});
    if (g >= 0) tb_last = g;
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic pend0, pend1;
  int   g;

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram_mem[i] <= 8'(i * 2);
      ref_mem[i] = 8'(i * 2);
    end
    reset = 1'b0;
    drv0(1'b1, 1'b1, 5'd1, 8'h11, 1'b0);
    drv1(1'b1, 1'b1, 5'd2, 8'h22, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt0", 32'(gnt0), 32'd0);
    check_eq("rst_gnt1", 32'(gnt1), 32'd0);
    check_eq("rst_wren", 32'(mem_wren), 32'd0);
    check_eq("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check_eq("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: single read of addr 5 (0x0A)
    drv0(1'b1, 1'b0, 5'd5, 8'h00, 1'b0);
    step(0);
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    drv1(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    step(1);
    drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    // 2: both requesting, grants alternate starting with port 0
    for (int i = 0; i < 4; i++) begin
      drv0(1'b1, 1'b0, 5'(i), 8'h00, 1'b0);
      drv1(1'b1, 1'b0, 5'(i + 8), 8'h00, 1'b0);
      step(i % 2);
    end
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    // 3: port 1 writes 0x3C to 7, port 0 reads it back next cycle
    drv1(1'b1, 1'b1, 5'd7, 8'h3C, 1'b0);
    step(1);
    drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    drv0(1'b1, 1'b0, 5'd7, 8'h00, 1'b0);
    step(0);
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    // 4: port 1 locks against a waiting port 0: 8 grants, then handover
    drv0(1'b1, 1'b0, 5'd4, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drv1(1'b1, 1'b0, 5'(9 + i), 8'h00, 1'b1);
      step(1);
      check_eq("lock_busy", 32'(busy), 32'd1);
    end
    step(0);
    check_eq("lock_release", 32'(busy), 32'd0);
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    // exhausted lock with no competitor keeps the grant, then yields at once
    for (int i = 0; i < 10; i++) begin
      drv0(1'b1, 1'b0, 5'(20 + i), 8'h00, 1'b1);
      step(0);
    end
    check_eq("sat_busy", 32'(busy), 32'd1);
    drv1(1'b1, 1'b0, 5'd30, 8'h00, 1'b0);
    step(1);
    drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    step(0);
    check_eq("relock_busy", 32'(busy), 32'd1);

    // 6: idle cycle releases the lock
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    step(-1);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // random traffic, requests held until granted
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1'b1;
        drv0(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             8'($urandom_range(0, 255)), 1'b0);
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1 = 1'b1;
        drv1(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             8'($urandom_range(0, 255)), 1'b0);
      end
      if (pend0 && pend1) g = (tb_last == 0) ? 1 : 0;
      else if (pend0)     g = 0;
      else if (pend1)     g = 1;
      else                g = -1;
      step(g);
      if (g == 0) begin pend0 = 1'b0; drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0); end
      if (g == 1) begin pend1 = 1'b0; drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0); end
    end
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    step(-1);
    step(-1);

    // 5: reset in the cycle after a granted, locked read
    drv0(1'b1, 1'b0, 5'd5, 8'h00, 1'b1);
    step(0);
    check_eq("pre_rst_rvalid0", 32'(rvalid0), 32'd1);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    drv0(1'b1, 1'b1, 5'd3, 8'h55, 1'b0);
    #2 reset = 1'b0;
    exp_q.delete();
    tb_last = 1;
    #1;
    check_eq("async_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check_eq("async_rdata0", 32'(rdata0), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("rst_hold_gnt0", 32'(gnt0), 32'd0);
    check_eq("rst_hold_wren", 32'(mem_wren), 32'd0);
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    drv0(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    drv1(1'b1, 1'b0, 5'd6, 8'h00, 1'b0);
    step(0);
    step(1);
    drv0(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    drv1(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    step(-1);
    step(-1);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
